// File: rtl/integer_issue_queue_pkg.sv
// Shared types and constants for the integer issue queue.
// Holds the queue geometry, operand/tag widths, integer opcode encodings
// and the packed per-entry payload stored in each queue slot.
package integer_issue_queue_pkg;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 6;
    localparam int unsigned OP_W   = 3;

    // Integer execution unit opcodes
    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_SLT = 3'b101;
    localparam logic [OP_W-1:0] OP_SLL = 3'b110;
    localparam logic [OP_W-1:0] OP_SRL = 3'b111;

    // One reservation entry
    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] rs_data;
        logic [TAG_W-1:0]  rs_tag;
        logic              rs_valid;
        logic [DATA_W-1:0] rt_data;
        logic [TAG_W-1:0]  rt_tag;
        logic              rt_valid;
        logic [OP_W-1:0]   opcode;
        logic [TAG_W-1:0]  rd_tag;
    } iq_entry_t;

endpackage

// File: rtl/iq_entry_wakeup.sv
// Combinational CDB snoop for one operand slot.
// Ports:
//   slot_valid          - the slot holds (or is receiving) a live instruction
//   op_valid/op_tag/op_data - current operand state
//   cdb_valid/cdb_tag/cdb_data - common data bus broadcast
//   op_valid_c/op_data_c - operand state after a possible capture
module iq_entry_wakeup
    import integer_issue_queue_pkg::*;
(
    input  logic              slot_valid,
    input  logic              op_valid,
    input  logic [TAG_W-1:0]  op_tag,
    input  logic [DATA_W-1:0] op_data,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              op_valid_c,
    output logic [DATA_W-1:0] op_data_c
);

    logic hit_c;

    // Only a still-pending operand may capture; a valid one keeps its value
    assign hit_c      = slot_valid & cdb_valid & ~op_valid & (op_tag == cdb_tag);
    assign op_valid_c = op_valid | hit_c;
    assign op_data_c  = hit_c ? cdb_data : op_data;

endmodule

// File: rtl/integer_issue_queue.sv
// Integer reservation queue: age-ordered entries (index 0 oldest), issue of
// the oldest fully ready entry, CDB operand wakeup, and compaction on issue.
// Ports:
//   clk, reset (sync, active-low)
//   dispatch_*      - instruction write from dispatch
//   issueque_full   - all entries occupied
//   cdb_*           - common data bus broadcast
//   issueque_ready  - a fully ready entry is presented
//   issueque_rs_data/rt_data/rd_tag/opcode - fields of the presented entry
//   issueblk_done   - issue block takes the presented entry
module integer_issue_queue
    import integer_issue_queue_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              dispatch_enable,
    input  logic [DATA_W-1:0] dispatch_rs_data,
    input  logic [DATA_W-1:0] dispatch_rt_data,
    input  logic [TAG_W-1:0]  dispatch_rs_tag,
    input  logic [TAG_W-1:0]  dispatch_rt_tag,
    input  logic              dispatch_rs_data_val,
    input  logic              dispatch_rt_data_val,
    input  logic [OP_W-1:0]   dispatch_opcode,
    input  logic [TAG_W-1:0]  dispatch_rd_tag,
    output logic              issueque_full,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    input  logic              cdb_valid,
    output logic              issueque_ready,
    output logic [DATA_W-1:0] issueque_rs_data,
    output logic [DATA_W-1:0] issueque_rt_data,
    output logic [TAG_W-1:0]  issueque_rd_tag,
    output logic [OP_W-1:0]   issueque_opcode,
    input  logic              issueblk_done
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    iq_entry_t         q       [DEPTH];
    iq_entry_t         woken_c [DEPTH];
    iq_entry_t         next_c  [DEPTH];
    iq_entry_t         disp_c;

    logic [DEPTH-1:0]  wk_rs_valid_c;
    logic [DEPTH-1:0]  wk_rt_valid_c;
    logic [DATA_W-1:0] wk_rs_data_c [DEPTH];
    logic [DATA_W-1:0] wk_rt_data_c [DEPTH];

    logic              disp_rs_valid_c;
    logic              disp_rt_valid_c;
    logic [DATA_W-1:0] disp_rs_data_c;
    logic [DATA_W-1:0] disp_rt_data_c;

    logic              ready_c;
    logic              full_c;
    logic              remove_c;
    logic [IDX_W-1:0]  sel_c;

    // CDB snoop for every stored operand
    for (genvar g = 0; g < DEPTH; g++) begin : g_wake
        iq_entry_wakeup u_rs (
            .slot_valid (q[g].valid),
            .op_valid   (q[g].rs_valid),
            .op_tag     (q[g].rs_tag),
            .op_data    (q[g].rs_data),
            .cdb_valid  (cdb_valid),
            .cdb_tag    (cdb_tag),
            .cdb_data   (cdb_data),
            .op_valid_c (wk_rs_valid_c[g]),
            .op_data_c  (wk_rs_data_c[g])
        );
        iq_entry_wakeup u_rt (
            .slot_valid (q[g].valid),
            .op_valid   (q[g].rt_valid),
            .op_tag     (q[g].rt_tag),
            .op_data    (q[g].rt_data),
            .cdb_valid  (cdb_valid),
            .cdb_tag    (cdb_tag),
            .cdb_data   (cdb_data),
            .op_valid_c (wk_rt_valid_c[g]),
            .op_data_c  (wk_rt_data_c[g])
        );
    end

    // CDB snoop for the instruction being dispatched this cycle
    iq_entry_wakeup u_disp_rs (
        .slot_valid (dispatch_enable),
        .op_valid   (dispatch_rs_data_val),
        .op_tag     (dispatch_rs_tag),
        .op_data    (dispatch_rs_data),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .op_valid_c (disp_rs_valid_c),
        .op_data_c  (disp_rs_data_c)
    );
    iq_entry_wakeup u_disp_rt (
        .slot_valid (dispatch_enable),
        .op_valid   (dispatch_rt_data_val),
        .op_tag     (dispatch_rt_tag),
        .op_data    (dispatch_rt_data),
        .cdb_valid  (cdb_valid),
        .cdb_tag    (cdb_tag),
        .cdb_data   (cdb_data),
        .op_valid_c (disp_rt_valid_c),
        .op_data_c  (disp_rt_data_c)
    );

    // Oldest-ready priority select and full detect on registered state
    always_comb begin
        sel_c   = '0;
        ready_c = 1'b0;
        full_c  = 1'b1;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (q[i].valid && q[i].rs_valid && q[i].rt_valid) begin
                sel_c   = IDX_W'(i);
                ready_c = 1'b1;
            end
            if (!q[i].valid) begin
                full_c = 1'b0;
            end
        end
    end

    assign remove_c = issueblk_done & ready_c;

    // Merge captured operands back into each entry
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            woken_c[i]          = q[i];
            woken_c[i].rs_valid = wk_rs_valid_c[i];
            woken_c[i].rs_data  = wk_rs_data_c[i];
            woken_c[i].rt_valid = wk_rt_valid_c[i];
            woken_c[i].rt_data  = wk_rt_data_c[i];
        end
    end

    // Incoming entry, with any same-cycle CDB capture already applied
    always_comb begin
        disp_c          = '0;
        disp_c.valid    = 1'b1;
        disp_c.rs_data  = disp_rs_data_c;
        disp_c.rs_tag   = dispatch_rs_tag;
        disp_c.rs_valid = disp_rs_valid_c;
        disp_c.rt_data  = disp_rt_data_c;
        disp_c.rt_tag   = dispatch_rt_tag;
        disp_c.rt_valid = disp_rt_valid_c;
        disp_c.opcode   = dispatch_opcode;
        disp_c.rd_tag   = dispatch_rd_tag;
    end

    // Compact over the issued slot, then append dispatch at the first hole
    always_comb begin
        logic written;
        written = 1'b0;
        for (int i = 0; i < DEPTH - 1; i++) begin
            next_c[i] = (remove_c && (IDX_W'(i) >= sel_c)) ? woken_c[i + 1] : woken_c[i];
        end
        next_c[DEPTH - 1] = remove_c ? '0 : woken_c[DEPTH - 1];
        // full_c is pre-issue state: no issue-to-dispatch bypass
        if (dispatch_enable && !full_c) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!written && !next_c[i].valid) begin
                    next_c[i] = disp_c;
                    written   = 1'b1;
                end
            end
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!reset) begin
                q[i] <= '0;
            end else begin
                q[i] <= next_c[i];
            end
        end
    end

    assign issueque_ready   = ready_c;
    assign issueque_full    = full_c;
    assign issueque_rs_data = ready_c ? q[sel_c].rs_data : '0;
    assign issueque_rt_data = ready_c ? q[sel_c].rt_data : '0;
    assign issueque_rd_tag  = ready_c ? q[sel_c].rd_tag  : '0;
    assign issueque_opcode  = ready_c ? q[sel_c].opcode  : '0;

endmodule

// File: tb/tb_integer_issue_queue.sv
// Bench for integer_issue_queue: directed vector table followed by random
// traffic compared against a queue-based reference model.
module tb_integer_issue_queue;
    import integer_issue_queue_pkg::*;

    logic        clk;
    logic        reset;
    logic        dispatch_enable;
    logic [31:0] dispatch_rs_data, dispatch_rt_data;
    logic [5:0]  dispatch_rs_tag, dispatch_rt_tag;
    logic        dispatch_rs_data_val, dispatch_rt_data_val;
    logic [2:0]  dispatch_opcode;
    logic [5:0]  dispatch_rd_tag;
    logic        issueque_full;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        cdb_valid;
    logic        issueque_ready;
    logic [31:0] issueque_rs_data, issueque_rt_data;
    logic [5:0]  issueque_rd_tag;
    logic [2:0]  issueque_opcode;
    logic        issueblk_done;

    int total = 0;
    int bad   = 0;

    integer_issue_queue dut (
        .clk                  (clk),
        .reset                (reset),
        .dispatch_enable      (dispatch_enable),
        .dispatch_rs_data     (dispatch_rs_data),
        .dispatch_rt_data     (dispatch_rt_data),
        .dispatch_rs_tag      (dispatch_rs_tag),
        .dispatch_rt_tag      (dispatch_rt_tag),
        .dispatch_rs_data_val (dispatch_rs_data_val),
        .dispatch_rt_data_val (dispatch_rt_data_val),
        .dispatch_opcode      (dispatch_opcode),
        .dispatch_rd_tag      (dispatch_rd_tag),
        .issueque_full        (issueque_full),
        .cdb_tag              (cdb_tag),
        .cdb_data             (cdb_data),
        .cdb_valid            (cdb_valid),
        .issueque_ready       (issueque_ready),
        .issueque_rs_data     (issueque_rs_data),
        .issueque_rt_data     (issueque_rt_data),
        .issueque_rd_tag      (issueque_rd_tag),
        .issueque_opcode      (issueque_opcode),
        .issueblk_done        (issueblk_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an age-ordered list of instructions
    typedef struct {
        logic [31:0] rs_d, rt_d;
        logic [5:0]  rs_t, rt_t;
        logic        rs_v, rt_v;
        logic [2:0]  op;
        logic [5:0]  rd;
    } ment_t;

    ment_t mq[$];

    typedef struct {
        logic        rst_n, de;
        logic [31:0] rs_d;
        logic        rs_v;
        logic [5:0]  rs_t;
        logic [31:0] rt_d;
        logic        rt_v;
        logic [5:0]  rt_t;
        logic [2:0]  op;
        logic [5:0]  rd;
        logic        cv;
        logic [5:0]  ct;
        logic [31:0] cd;
        logic        done;
        logic        e_rdy, e_full;
        logic [31:0] e_rs, e_rt;
        logic [5:0]  e_rd;
        logic [2:0]  e_op;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst_n, input logic de,
        input logic [31:0] rs_d, input logic rs_v, input logic [5:0] rs_t,
        input logic [31:0] rt_d, input logic rt_v, input logic [5:0] rt_t,
        input logic [2:0] op, input logic [5:0] rd,
        input logic cv, input logic [5:0] ct, input logic [31:0] cd, input logic done,
        input logic e_rdy, input logic e_full, input logic [31:0] e_rs, input logic [31:0] e_rt,
        input logic [5:0] e_rd, input logic [2:0] e_op);
        vec_t v;
        v.rst_n = rst_n; v.de = de;
        v.rs_d = rs_d; v.rs_v = rs_v; v.rs_t = rs_t;
        v.rt_d = rt_d; v.rt_v = rt_v; v.rt_t = rt_t;
        v.op = op; v.rd = rd;
        v.cv = cv; v.ct = ct; v.cd = cd; v.done = done;
        v.e_rdy = e_rdy; v.e_full = e_full; v.e_rs = e_rs; v.e_rt = e_rt;
        v.e_rd = e_rd; v.e_op = e_op;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ment_t wake(input ment_t e);
        ment_t r = e;
        if (cdb_valid && !r.rs_v && r.rs_t == cdb_tag) begin
            r.rs_v = 1'b1;
            r.rs_d = cdb_data;
        end
        if (cdb_valid && !r.rt_v && r.rt_t == cdb_tag) begin
            r.rt_v = 1'b1;
            r.rt_d = cdb_data;
        end
        return r;
    endfunction

    function automatic int model_sel();
        int s = -1;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rs_v && mq[i].rt_v) s = i;
        end
        return s;
    endfunction

    // Advance the model across one clock edge using the driven inputs
    function automatic void model_update();
        int    s;
        bit    was_full;
        ment_t n;
        if (!reset) begin
            mq.delete();
            return;
        end
        was_full = (mq.size() == int'(DEPTH));
        s = model_sel();
        if (issueblk_done && s >= 0) mq.delete(s);
        for (int i = 0; i < mq.size(); i++) mq[i] = wake(mq[i]);
        if (dispatch_enable && !was_full) begin
            n.rs_d = dispatch_rs_data; n.rs_t = dispatch_rs_tag; n.rs_v = dispatch_rs_data_val;
            n.rt_d = dispatch_rt_data; n.rt_t = dispatch_rt_tag; n.rt_v = dispatch_rt_data_val;
            n.op = dispatch_opcode; n.rd = dispatch_rd_tag;
            mq.push_back(wake(n));
        end
    endfunction

    task automatic check_model(input string pfx);
        int          s = model_sel();
        logic [31:0] ers = '0, ert = '0;
        logic [5:0]  erd = '0;
        logic [2:0]  eop = '0;
        if (s >= 0) begin
            ers = mq[s].rs_d; ert = mq[s].rt_d; erd = mq[s].rd; eop = mq[s].op;
        end
        check({pfx, ".ready"}, 32'(issueque_ready), 32'(s >= 0));
        check({pfx, ".full"},  32'(issueque_full),  32'(mq.size() == int'(DEPTH)));
        check({pfx, ".rs"},    issueque_rs_data,    ers);
        check({pfx, ".rt"},    issueque_rt_data,    ert);
        check({pfx, ".rd"},    32'(issueque_rd_tag), 32'(erd));
        check({pfx, ".op"},    32'(issueque_opcode), 32'(eop));
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; dispatch_enable = 1'b0;
        dispatch_rs_data = '0; dispatch_rt_data = '0; dispatch_rs_tag = '0; dispatch_rt_tag = '0;
        dispatch_rs_data_val = 1'b0; dispatch_rt_data_val = 1'b0;
        dispatch_opcode = '0; dispatch_rd_tag = '0;
        cdb_tag = '0; cdb_data = '0; cdb_valid = 1'b0; issueblk_done = 1'b0;

        // rst,de, rs_d,rs_v,rs_t, rt_d,rt_v,rt_t, op,rd, cv,ct,cd, done | rdy,full, rs,rt, rd,op
        vecs.push_back(mk(0,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 0,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        vecs.push_back(mk(0,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 0,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        vecs.push_back(mk(1,1, 32'h11111111,1,6'd0, 32'h11111111,1,6'd0, OP_AND,6'd10, 0,6'd0,32'h0, 0,  1,0, 32'h11111111,32'h11111111, 6'd10,OP_AND));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 1,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        // pending rt woken by CDB
        vecs.push_back(mk(1,1, 32'h22222222,1,6'd0, 32'h0,0,6'd20, OP_SUB,6'd11, 0,6'd0,32'h0, 0,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 0,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 1,6'd20,32'h22222222, 0,  1,0, 32'h22222222,32'h22222222, 6'd11,OP_SUB));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 1,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        // fill: A ready, B waiting on tag 30, C ready, D ready; E dropped
        vecs.push_back(mk(1,1, 32'h11111111,1,6'd0, 32'h11111111,1,6'd0, OP_ADD,6'd1, 0,6'd0,32'h0, 0,  1,0, 32'h11111111,32'h11111111, 6'd1,OP_ADD));
        vecs.push_back(mk(1,1, 32'h22222222,1,6'd0, 32'h0,0,6'd30, OP_SUB,6'd2, 0,6'd0,32'h0, 0,  1,0, 32'h11111111,32'h11111111, 6'd1,OP_ADD));
        vecs.push_back(mk(1,1, 32'h33333333,1,6'd0, 32'h33333333,1,6'd0, OP_OR,6'd3, 0,6'd0,32'h0, 0,  1,0, 32'h11111111,32'h11111111, 6'd1,OP_ADD));
        vecs.push_back(mk(1,1, 32'h44444444,1,6'd0, 32'h44444444,1,6'd0, OP_XOR,6'd4, 0,6'd0,32'h0, 0,  1,1, 32'h11111111,32'h11111111, 6'd1,OP_ADD));
        vecs.push_back(mk(1,1, 32'hDEADBEEF,1,6'd0, 32'hDEADBEEF,1,6'd0, OP_SLT,6'd12, 0,6'd0,32'h0, 0,  1,1, 32'h11111111,32'h11111111, 6'd1,OP_ADD));
        // oldest-first issue skipping the waiting entry
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 1,  1,0, 32'h33333333,32'h33333333, 6'd3,OP_OR));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 1,  1,0, 32'h44444444,32'h44444444, 6'd4,OP_XOR));
        // refill
        vecs.push_back(mk(1,1, 32'h55555555,1,6'd0, 32'h55555555,1,6'd0, OP_SLL,6'd5, 0,6'd0,32'h0, 0,  1,0, 32'h44444444,32'h44444444, 6'd4,OP_XOR));
        vecs.push_back(mk(1,1, 32'h66666666,1,6'd0, 32'h66666666,1,6'd0, OP_SRL,6'd6, 0,6'd0,32'h0, 0,  1,1, 32'h44444444,32'h44444444, 6'd4,OP_XOR));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 1,  1,0, 32'h55555555,32'h55555555, 6'd5,OP_SLL));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 1,  1,0, 32'h66666666,32'h66666666, 6'd6,OP_SRL));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 1,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 1,6'd30,32'h77777777, 0,  1,0, 32'h22222222,32'h77777777, 6'd2,OP_SUB));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 1,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        // dispatch captures a same-cycle broadcast
        vecs.push_back(mk(1,1, 32'h12345678,1,6'd0, 32'h0,0,6'd2, OP_OR,6'd13, 1,6'd2,32'h22222222, 0,  1,0, 32'h12345678,32'h22222222, 6'd13,OP_OR));
        // reset mid-operation discards entries and the in-flight dispatch
        vecs.push_back(mk(0,1, 32'hCAFEF00D,1,6'd0, 32'hCAFEF00D,1,6'd0, OP_AND,6'd7, 0,6'd0,32'h0, 0,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        // both operands wake on one broadcast at dispatch
        vecs.push_back(mk(1,1, 32'h0,0,6'd5, 32'h0,0,6'd5, OP_XOR,6'd14, 1,6'd5,32'hABCD0123, 0,  1,0, 32'hABCD0123,32'hABCD0123, 6'd14,OP_XOR));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 1,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        // done while not ready is ignored; invalid CDB does not wake
        vecs.push_back(mk(1,1, 32'h00001234,1,6'd0, 32'h0,0,6'd9, OP_ADD,6'd15, 0,6'd0,32'h0, 0,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd9,32'hFFFF0000, 1,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 1,6'd9,32'h00009999, 0,  1,0, 32'h00001234,32'h00009999, 6'd15,OP_ADD));
        vecs.push_back(mk(1,0, 32'h0,0,6'd0, 32'h0,0,6'd0, OP_ADD,6'd0, 0,6'd0,32'h0, 1,  0,0, 32'h0,32'h0, 6'd0,OP_ADD));

        for (int v = 0; v < vecs.size(); v++) begin
            reset                = vecs[v].rst_n;
            dispatch_enable      = vecs[v].de;
            dispatch_rs_data     = vecs[v].rs_d;
            dispatch_rs_data_val = vecs[v].rs_v;
            dispatch_rs_tag      = vecs[v].rs_t;
            dispatch_rt_data     = vecs[v].rt_d;
            dispatch_rt_data_val = vecs[v].rt_v;
            dispatch_rt_tag      = vecs[v].rt_t;
            dispatch_opcode      = vecs[v].op;
            dispatch_rd_tag      = vecs[v].rd;
            cdb_valid            = vecs[v].cv;
            cdb_tag              = vecs[v].ct;
            cdb_data             = vecs[v].cd;
            issueblk_done        = vecs[v].done;
            tick();
            check($sformatf("vec%0d.ready", v), 32'(issueque_ready),  32'(vecs[v].e_rdy));
            check($sformatf("vec%0d.full", v),  32'(issueque_full),   32'(vecs[v].e_full));
            check($sformatf("vec%0d.rs", v),    issueque_rs_data,     vecs[v].e_rs);
            check($sformatf("vec%0d.rt", v),    issueque_rt_data,     vecs[v].e_rt);
            check($sformatf("vec%0d.rd", v),    32'(issueque_rd_tag), 32'(vecs[v].e_rd));
            check($sformatf("vec%0d.op", v),    32'(issueque_opcode), 32'(vecs[v].e_op));
            check_model($sformatf("vec%0d.model", v));
        end

        // Random traffic against the model; small tag space forces CDB hits
        for (int c = 0; c < 3000; c++) begin
            reset                = ($urandom_range(63, 0) != 0);
            dispatch_enable      = 1'($urandom_range(1, 0));
            dispatch_rs_data     = $urandom;
            dispatch_rt_data     = $urandom;
            dispatch_rs_data_val = 1'($urandom_range(1, 0));
            dispatch_rt_data_val = 1'($urandom_range(1, 0));
            dispatch_rs_tag      = 6'($urandom_range(7, 0));
            dispatch_rt_tag      = 6'($urandom_range(7, 0));
            dispatch_opcode      = 3'($urandom);
            dispatch_rd_tag      = 6'($urandom);
            cdb_valid            = ($urandom_range(9, 0) < 4);
            cdb_tag              = 6'($urandom_range(7, 0));
            cdb_data             = $urandom;
            issueblk_done        = 1'($urandom_range(1, 0));
            tick();
            check_model($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
